// File: rtl/pe_feeder.sv
// Skew feeder for a systolic array: lane i of each accepted vector is delayed i+1 cycles,
// with zero bubbles on idle edges. Optional per-lane valid output under PE_FEEDER_LANE_VALID_EN.
module pe_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int PE_DIM     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH*PE_DIM-1:0] in_data,
    input  logic                         in_last,
    output logic [DATA_WIDTH*PE_DIM-1:0] data_out,
    output logic                         busy,
    output logic                         done
`ifdef PE_FEEDER_LANE_VALID_EN
    ,
    output logic [PE_DIM-1:0]            lane_valid
`endif
);

    localparam int CNT_W = (PE_DIM > 1) ? $clog2(PE_DIM) : 1;
    // Drain ends once the last lane's element has one stage left to travel.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((PE_DIM > 1) ? (PE_DIM - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;
    logic             busy_r;
    logic             in_ready_s;
    logic             accept_s;

    // Handshake: no new vectors while the tail of a batch is draining out.
    always_comb begin
        in_ready_s = en & (state_r != ST_DRAIN);
        accept_s   = in_valid & in_ready_s;
    end

    assign in_ready = in_ready_s;
    assign busy     = busy_r;
    assign done     = done_r;

    // Batch control FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (en) begin
                case (state_r)
                    ST_IDLE, ST_STREAM: begin
                        if (accept_s) begin
                            if (in_last) begin
                                if (PE_DIM == 1) begin
                                    state_r <= ST_IDLE;
                                    done_r  <= 1'b1;
                                    busy_r  <= 1'b0;
                                end else begin
                                    state_r <= ST_DRAIN;
                                    cnt_r   <= {CNT_W{1'b0}};
                                    busy_r  <= 1'b1;
                                end
                            end else begin
                                state_r <= ST_STREAM;
                                busy_r  <= 1'b1;
                            end
                        end else begin
                            state_r <= state_r;
                            busy_r  <= busy_r;
                        end
                    end
                    ST_DRAIN: begin
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= {CNT_W{1'b0}};
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < PE_DIM; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] pipe_r [0:i];
        logic [DATA_WIDTH-1:0] head_s;

        // Stage-0 input: the accepted element, or a zero bubble.
        always_comb begin
            if (accept_s) begin
                head_s = in_data[DATA_WIDTH*i +: DATA_WIDTH];
            end else begin
                head_s = {DATA_WIDTH{1'b0}};
            end
        end

        // Lane delay line of i+1 stages, frozen while en is low.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= i; j++) begin
                    pipe_r[j] <= {DATA_WIDTH{1'b0}};
                end
            end else if (en) begin
                pipe_r[0] <= head_s;
                for (int j = 1; j <= i; j++) begin
                    pipe_r[j] <= pipe_r[j-1];
                end
            end
        end

        assign data_out[DATA_WIDTH*i +: DATA_WIDTH] = pipe_r[i];

`ifdef PE_FEEDER_LANE_VALID_EN
        logic vld_r [0:i];

        // Valid tag travels alongside the lane data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= i; j++) begin
                    vld_r[j] <= 1'b0;
                end
            end else if (en) begin
                vld_r[0] <= accept_s;
                for (int j = 1; j <= i; j++) begin
                    vld_r[j] <= vld_r[j-1];
                end
            end
        end

        assign lane_valid[i] = vld_r[i];
`endif
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder (PE_DIM=4, DATA_WIDTH=8): per-lane expected-element queues plus
// directed batch scenarios; lane_valid is checked when PE_FEEDER_LANE_VALID_EN is defined.
module tb_pe_feeder;
    localparam int DW = 8;
    localparam int PD = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW*PD-1:0] in_data = '0;
    logic            in_last = 1'b0;
    logic [DW*PD-1:0] data_out;
    logic            busy;
    logic            done;
`ifdef PE_FEEDER_LANE_VALID_EN
    logic [PD-1:0]   lane_valid;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pe_feeder #(.DATA_WIDTH(DW), .PE_DIM(PD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .data_out(data_out), .busy(busy), .done(done)
`ifdef PE_FEEDER_LANE_VALID_EN
        , .lane_valid(lane_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane_of(input logic [31:0] v, input int i);
        return v[8*i +: 8];
    endfunction

    // Scoreboard: each enabled edge pushes the element expected to enter every lane;
    // lane i shows the element pushed i enabled edges earlier.
    logic [7:0] lane_q [PD][$];
    bit         vld_q  [PD][$];
    bit         m_drain = 1'b0;
    bit         m_busy  = 1'b0;
    bit         m_done  = 1'b0;
    int         m_left  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PD; i++) begin
                lane_q[i].delete();
                vld_q[i].delete();
            end
            m_drain = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            bit acc;
            m_done = 1'b0;
            if (en) begin
                acc = in_valid && !m_drain;
                for (int i = 0; i < PD; i++) begin
                    lane_q[i].push_back(acc ? lane_of(in_data, i) : 8'h00);
                    vld_q[i].push_back(acc);
                    if (lane_q[i].size() > i + 1) begin
                        void'(lane_q[i].pop_front());
                        void'(vld_q[i].pop_front());
                    end
                end
                if (m_drain) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_drain = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                    end
                end else if (acc) begin
                    m_busy = 1'b1;
                    if (in_last) begin
                        m_drain = 1'b1; m_left = PD - 1;
                    end
                end
            end
        end
    end

    // Compare every output against the scoreboard on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < PD; i++) begin
            check_eq($sformatf("lane%0d", i), {24'h0, lane_of(data_out, i)},
                     (lane_q[i].size() == i + 1) ? {24'h0, lane_q[i][0]} : 32'h0);
`ifdef PE_FEEDER_LANE_VALID_EN
            check_eq($sformatf("vld%0d", i), {31'h0, lane_valid[i]},
                     (vld_q[i].size() == i + 1) ? {31'h0, vld_q[i][0]} : 32'h0);
`endif
        end
        check_eq("done", {31'h0, done}, {31'h0, m_done});
        check_eq("busy", {31'h0, busy}, {31'h0, m_busy});
        check_eq("in_ready", {31'h0, in_ready}, {31'h0, en && !m_drain});
    end

    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit e);
        in_valid = v; in_data = d; in_last = l; en = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic single_batch(input string tag);
        step(1'b1, 32'h04030201, 1'b1, 1'b1);
        check_eq({tag, "_c1_l0"}, {24'h0, lane_of(data_out, 0)}, 32'h01);
        check_eq({tag, "_c1_rdy"}, {31'h0, in_ready}, 32'h0);
        idle(1);
        check_eq({tag, "_c2_l1"}, {24'h0, lane_of(data_out, 1)}, 32'h02);
        check_eq({tag, "_c2_rdy"}, {31'h0, in_ready}, 32'h0);
        idle(1);
        check_eq({tag, "_c3_l2"}, {24'h0, lane_of(data_out, 2)}, 32'h03);
        check_eq({tag, "_c3_done"}, {31'h0, done}, 32'h0);
        idle(1);
        check_eq({tag, "_c4_l3"}, {24'h0, lane_of(data_out, 3)}, 32'h04);
        check_eq({tag, "_c4_done"}, {31'h0, done}, 32'h1);
        idle(1);
        check_eq({tag, "_c5_done"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        int cyc;
        bit seen;
        // Reset state
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("rst_dout", data_out, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Single vector with in_last
        single_batch("r31");
        idle(2);

        // Three back-to-back vectors
        step(1'b1, 32'h11111111, 1'b0, 1'b1);
        check_eq("r32_c1_l0", {24'h0, lane_of(data_out, 0)}, 32'h11);
        step(1'b1, 32'h22222222, 1'b0, 1'b1);
        check_eq("r32_c2_l0", {24'h0, lane_of(data_out, 0)}, 32'h22);
        step(1'b1, 32'h33333333, 1'b1, 1'b1);
        check_eq("r32_c3_l0", {24'h0, lane_of(data_out, 0)}, 32'h33);
        idle(1);
        check_eq("r32_c4_l3", {24'h0, lane_of(data_out, 3)}, 32'h11);
        idle(1);
        check_eq("r32_c5_l3", {24'h0, lane_of(data_out, 3)}, 32'h22);
        check_eq("r32_c5_done", {31'h0, done}, 32'h0);
        idle(1);
        check_eq("r32_c6_l3", {24'h0, lane_of(data_out, 3)}, 32'h33);
        check_eq("r32_c6_done", {31'h0, done}, 32'h1);
        idle(2);

        // Two-cycle valid gap mid-batch
        step(1'b1, 32'hA4A3A2A1, 1'b0, 1'b1);
        step(1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
        check_eq("r33_gap_l0", {24'h0, lane_of(data_out, 0)}, 32'h00);
        check_eq("r33_gap_busy", {31'h0, busy}, 32'h1);
        step(1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
        check_eq("r33_gap_rdy", {31'h0, in_ready}, 32'h1);
        step(1'b1, 32'hB4B3B2B1, 1'b1, 1'b1);
        idle(1);
        check_eq("r33_l2_bub", {24'h0, lane_of(data_out, 2)}, 32'h00);
        idle(5);

        // en low for 3 cycles during drain delays done by 3
        step(1'b1, 32'hC4C3C2C1, 1'b1, 1'b1);
        cyc = 1;
        idle(1); cyc++;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0); cyc++;
            check_eq("r34_frz_l1", {24'h0, lane_of(data_out, 1)}, 32'hC2);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (done) seen = 1'b1;
            else begin idle(1); cyc++; end
        end
        check_eq("r34_done_seen", {31'h0, seen}, 32'h1);
        check_eq("r34_done_cyc", cyc, 32'd7);
        idle(2);

        // Async reset in cycle 2 of a drain
        step(1'b1, 32'hD4D3D2D1, 1'b1, 1'b1);
        idle(1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("r35_dout", data_out, 32'h0);
        check_eq("r35_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        single_batch("r35b");
        idle(2);

        // Random traffic against the scoreboard
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0));
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
